// File: rtl/hw_cell_alloc.sv
// hw_cell_alloc: per-port GSM cell allocator with internal free list; HW_CELL_ALLOC_STATS_EN adds a saturating drop counter
module hw_cell_alloc #(
  parameter int MWIDTH      = 4,
  parameter int MAX_PKT_LEN = 7,
  parameter int AWIDTH      = 7,
  parameter int HM_OFFSET   = 0,
  parameter int RESERVE     = 0,
  parameter int DCNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic [MAX_PKT_LEN-1:0] i_ingress_pkt_length,
  input  logic [31:0]            i_ingress_dest_ip,
  input  logic                   i_ingress_valid,
  input  logic                   i_ingress_header,
  output logic [MWIDTH-1:0]      o_gsm_multicast,
  output logic [AWIDTH-1:0]      o_gsm_cell_addr,
  output logic                   o_gsm_wr_en,
  output logic                   o_gsm_sop,
  input  logic                   i_free_valid,
  input  logic [AWIDTH-1:0]      i_free_addr,
  output logic [AWIDTH:0]        o_avail_cnt,
  output logic                   o_drop_pulse,
  output logic                   o_len_err,
  output logic                   o_free_err,
  output logic [DCNT_WIDTH-1:0]  o_drop_cnt
);
  localparam int NCELL = 1 << AWIDTH;
  localparam int CW = (MAX_PKT_LEN > AWIDTH ? MAX_PKT_LEN : AWIDTH) + 2;
  localparam logic [AWIDTH:0] ONE_A = 1;
  localparam logic [MAX_PKT_LEN-1:0] ONE_L = 1;
  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;
  state_t r_state, w_state_nxt;
  logic [MAX_PKT_LEN-1:0] r_rem;
  logic [AWIDTH:0] r_init_gen, r_head, r_tail, r_avail;
  logic [AWIDTH-1:0] r_fifo [NCELL];
  logic [MWIDTH-1:0] r_mcast, w_mc;
  logic [AWIDTH-1:0] w_addr;
  logic w_rst, w_pass, w_hdr, w_body, w_accept, w_alloc, w_len_err, w_trunc, w_free_ok, w_unused;
  assign w_rst = ~rst_n | clr;
  assign w_mc = i_ingress_dest_ip[HM_OFFSET +: MWIDTH];
  assign w_unused = ^i_ingress_dest_ip;
  assign w_pass = r_state == PASS;
  assign w_hdr = i_ingress_valid & i_ingress_header;
  assign w_body = i_ingress_valid & ~i_ingress_header & w_pass;
  assign w_accept = w_hdr && w_mc != '0 && i_ingress_pkt_length != '0 &&
                    CW'(i_ingress_pkt_length) + CW'(RESERVE) <= CW'(r_avail);
  assign w_alloc = w_accept | (w_body & (r_rem != '0));
  assign w_len_err = w_body & (r_rem == '0);
  assign w_trunc = w_hdr & w_pass & (r_rem != '0);
  // Pool is full when FIFO occupancy equals the number of init addresses already handed out
  assign w_free_ok = i_free_valid & ((r_tail - r_head) != r_init_gen);
  assign w_addr = r_init_gen[AWIDTH] ? r_fifo[r_head[AWIDTH-1:0]] : r_init_gen[AWIDTH-1:0];
  assign o_avail_cnt = r_avail;
  always_comb begin
    w_state_nxt = r_state;
    if (w_hdr) w_state_nxt = w_accept ? PASS : DROP;
  end
  always_ff @(posedge clk)
    if (w_rst) r_state <= IDLE;
    else r_state <= w_state_nxt;
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_rem           <= '0;
      r_init_gen      <= '0;
      r_head          <= '0;
      r_tail          <= '0;
      r_avail         <= (AWIDTH+1)'(NCELL);
      r_mcast         <= '0;
      o_gsm_multicast <= '0;
      o_gsm_cell_addr <= '0;
      o_gsm_wr_en     <= 1'b0;
      o_gsm_sop       <= 1'b0;
      o_drop_pulse    <= 1'b0;
      o_len_err       <= 1'b0;
      o_free_err      <= 1'b0;
    end else begin
      r_avail <= (AWIDTH+1)'(CW'(r_avail) - (w_accept ? CW'(i_ingress_pkt_length) : '0) +
                             CW'(w_free_ok) + (w_trunc ? CW'(r_rem) : '0));
      if (w_hdr) r_rem <= w_accept ? i_ingress_pkt_length - ONE_L : '0;
      else if (w_alloc) r_rem <= r_rem - ONE_L;
      if (w_alloc) begin
        if (r_init_gen[AWIDTH]) r_head <= r_head + ONE_A;
        else r_init_gen <= r_init_gen + ONE_A;
        o_gsm_cell_addr <= w_addr;
        o_gsm_multicast <= w_accept ? w_mc : r_mcast;
      end
      if (w_accept) r_mcast <= w_mc;
      if (w_free_ok) r_tail <= r_tail + ONE_A;
      o_gsm_wr_en  <= w_alloc;
      o_gsm_sop    <= w_accept;
      o_drop_pulse <= w_hdr & ~w_accept;
      o_len_err    <= w_len_err;
      o_free_err   <= i_free_valid & ~w_free_ok;
    end
  end
  always_ff @(posedge clk)
    if (w_free_ok) r_fifo[r_tail[AWIDTH-1:0]] <= i_free_addr;
`ifdef HW_CELL_ALLOC_STATS_EN
  localparam logic [DCNT_WIDTH-1:0] ONE_D = 1;
  logic [DCNT_WIDTH-1:0] r_drop_cnt;
  always_ff @(posedge clk)
    if (w_rst) r_drop_cnt <= '0;
    else if (w_hdr && !w_accept && !(&r_drop_cnt)) r_drop_cnt <= r_drop_cnt + ONE_D;
  assign o_drop_cnt = r_drop_cnt;
`else
  assign o_drop_cnt = '0;
`endif
endmodule

// File: tb/tb_hw_cell_alloc.sv
// tb_hw_cell_alloc: directed and randomized checks of hw_cell_alloc against a queue-based pool model
module tb_hw_cell_alloc;
  localparam int AW = 3, NC = 8, RS = 2, HO = 8;
  logic clk = 0, rst_n = 0, clr = 0;
  logic [6:0] len = 0;
  logic [31:0] dest = 0;
  logic valid = 0, header = 0, free_valid = 0;
  logic [AW-1:0] free_addr = 0;
  logic [3:0] o_mc;
  logic [AW-1:0] o_addr;
  logic o_wr, o_sop, o_drop, o_lerr, o_ferr;
  logic [AW:0] o_avail;
  logic [15:0] o_dcnt;
  int n_checks = 0, n_err = 0;
  always #5 clk = ~clk;
  hw_cell_alloc #(.MWIDTH(4), .MAX_PKT_LEN(7), .AWIDTH(AW), .HM_OFFSET(HO), .RESERVE(RS), .DCNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .i_ingress_pkt_length(len), .i_ingress_dest_ip(dest), .i_ingress_valid(valid), .i_ingress_header(header),
    .o_gsm_multicast(o_mc), .o_gsm_cell_addr(o_addr), .o_gsm_wr_en(o_wr), .o_gsm_sop(o_sop),
    .i_free_valid(free_valid), .i_free_addr(free_addr), .o_avail_cnt(o_avail),
    .o_drop_pulse(o_drop), .o_len_err(o_lerr), .o_free_err(o_ferr), .o_drop_cnt(o_dcnt));
  task automatic chk(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask
  int m_avail = NC, m_init = 0, m_rem = 0, m_dcnt = 0, m_mc = 0;
  bit m_pass = 0;
  int m_fifo[$], m_out[$];
  bit e_wr, e_sop, e_drop, e_len, e_ferr;
  int e_addr, e_mc, e_avail = NC;
  always @(posedge clk) begin : model
    int l, mc, a;
    bit hdr, body, acc, trunc, full, fok;
    int idx[$];
    if (!rst_n || clr) begin
      m_avail = NC; m_init = 0; m_rem = 0; m_pass = 0; m_mc = 0; m_dcnt = 0;
      m_fifo.delete(); m_out.delete();
      {e_wr, e_sop, e_drop, e_len, e_ferr} = '0;
      e_avail = NC;
    end else begin
      l = int'(len); mc = int'(dest[HO +: 4]);
      hdr = valid && header;
      body = valid && !header && m_pass;
      acc = hdr && mc != 0 && l != 0 && l + RS <= m_avail;
      trunc = hdr && m_pass && m_rem > 0;
      full = m_fifo.size() + (NC - m_init) == NC;
      fok = free_valid && !full;
      e_wr = acc || (body && m_rem > 0);
      e_sop = acc;
      e_drop = hdr && !acc;
      e_len = body && m_rem == 0;
      e_ferr = free_valid && full;
      e_avail = m_avail - (acc ? l : 0) + (fok ? 1 : 0) + (trunc ? m_rem : 0);
      if (e_wr) begin
        if (m_init < NC) begin a = m_init; m_init++; end
        else a = m_fifo.pop_front();
        e_addr = a;
        e_mc = acc ? mc : m_mc;
        m_out.push_back(a);
      end
      if (fok) begin
        m_fifo.push_back(int'(free_addr));
        idx = m_out.find_first_index(x) with (x == int'(free_addr));
        if (idx.size() > 0) m_out.delete(idx[0]);
      end
      if (hdr) begin
        m_pass = acc;
        m_rem = acc ? l - 1 : 0;
        if (acc) m_mc = mc;
      end else if (body && m_rem > 0) m_rem--;
      if (e_drop && m_dcnt < 65535) m_dcnt++;
      m_avail = e_avail;
    end
  end
  always @(negedge clk) begin
    chk("wr_en", o_wr, e_wr);
    chk("sop", o_sop, e_sop);
    chk("drop_pulse", o_drop, e_drop);
    chk("len_err", o_lerr, e_len);
    chk("free_err", o_ferr, e_ferr);
    chk("avail", o_avail, e_avail);
    if (e_wr) begin
      chk("cell_addr", o_addr, e_addr);
      chk("multicast", o_mc, e_mc);
    end
`ifdef HW_CELL_ALLOC_STATS_EN
    chk("drop_cnt", o_dcnt, m_dcnt);
`else
    chk("drop_cnt", o_dcnt, 0);
`endif
  end
  task automatic hdr(input int l, input int mc);
    dest = $urandom; dest[HO +: 4] = 4'(mc);
    len = 7'(l); valid = 1; header = 1;
    @(negedge clk);
    valid = 0; header = 0;
  endtask
  task automatic body();
    valid = 1; header = 0;
    @(negedge clk);
    valid = 0;
  endtask
  task automatic free(input int a);
    free_valid = 1; free_addr = AW'(a);
    @(negedge clk);
    free_valid = 0;
  endtask
  task automatic do_reset();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic expect_dcnt(input int v);
`ifdef HW_CELL_ALLOC_STATS_EN
    chk("lit drop_cnt", o_dcnt, v);
`else
    chk("lit drop_cnt off", o_dcnt, 0 * v);
`endif
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1;
    chk("lit reset avail", o_avail, NC);
    chk("lit reset wr_en", o_wr, 0);
    hdr(3, 4'b0101);
    chk("lit p1 addr0", o_addr, 0); chk("lit p1 sop", o_sop, 1);
    chk("lit p1 mc", o_mc, 5); chk("lit p1 avail", o_avail, 5);
    body(); chk("lit p1 addr1", o_addr, 1); chk("lit p1 sop1", o_sop, 0);
    body(); chk("lit p1 addr2", o_addr, 2); chk("lit p1 mc2", o_mc, 5);
    body(); chk("lit len_err", o_lerr, 1); chk("lit len_err wr", o_wr, 0); chk("lit len_err avail", o_avail, 5);
    do_reset();
    chk("lit rst2 avail", o_avail, NC);
    hdr(6, 3); chk("lit six avail", o_avail, 2);
    repeat (5) body();
    hdr(1, 1); chk("lit reserve drop", o_drop, 1); chk("lit reserve wr", o_wr, 0);
    expect_dcnt(1);
    free(5); chk("lit free5 avail", o_avail, 3);
    free(3); chk("lit free3 avail", o_avail, 4);
    hdr(2, 2); chk("lit init addr6", o_addr, 6);
    body(); chk("lit init addr7", o_addr, 7); chk("lit avail 2", o_avail, 2);
    free(0); free(1); chk("lit avail 4", o_avail, 4);
    hdr(2, 2); chk("lit fifo addr5", o_addr, 5);
    body(); chk("lit fifo addr3", o_addr, 3);
    foreach (m_out[i]) ;
    free(2); free(4); free(6); free(7); free(3); free(5);
    chk("lit all free avail", o_avail, NC);
    hdr(4, 9); chk("lit trunc addr", o_addr, 0); chk("lit trunc avail0", o_avail, 4);
    body(); chk("lit trunc addr1", o_addr, 1);
    hdr(2, 6); chk("lit trunc sop", o_sop, 1); chk("lit trunc addr2", o_addr, 2);
    chk("lit trunc avail", o_avail, 8 - 4 + 2 - 2); chk("lit trunc mc", o_mc, 6);
    body(); chk("lit trunc addr4", o_addr, 4);
    body(); chk("lit len_err2", o_lerr, 1); chk("lit len_err2 avail", o_avail, 4);
    free(0); free(1); free(2); free(4);
    chk("lit pool full avail", o_avail, NC);
    free(3); chk("lit free_err", o_ferr, 1); chk("lit free_err avail", o_avail, NC);
    hdr(3, 0); chk("lit mc0 drop", o_drop, 1);
    hdr(0, 5); chk("lit len0 drop", o_drop, 1); chk("lit len0 wr", o_wr, 0);
    expect_dcnt(3);
    for (int c = 0; c < 4000; c++) begin
      valid = $urandom_range(0, 3) != 0;
      header = $urandom_range(0, 4) == 0;
      len = 7'($urandom_range(0, 7));
      dest = $urandom;
      free_valid = $urandom_range(0, 2) == 0;
      free_addr = (m_out.size() > 0) ? AW'(m_out[$urandom_range(0, m_out.size() - 1)]) : AW'($urandom_range(0, NC - 1));
      clr = $urandom_range(0, 299) == 0;
      rst_n = $urandom_range(0, 499) != 0;
      @(negedge clk);
    end
    {valid, header, free_valid, clr} = '0;
    rst_n = 1;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
